// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM stage and a single-port data RAM.
// Stores are queued and drained in FIFO order on cycles without an accepted CPU access.
module store_buffer #(
   parameter int DEPTH      = 4,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_ce_i,
   input  logic        mem_we_i,
   input  logic [31:0] mem_addr_i,
   input  logic [3:0]  mem_sel_i,
   input  logic [31:0] mem_data_i,
   output logic [31:0] mem_data_o,
   output logic        stall_req_o,
   output logic        ram_ce_o,
   output logic        ram_we_o,
   output logic [31:0] ram_addr_o,
   output logic [3:0]  ram_sel_o,
   output logic [31:0] ram_data_o,
   input  logic [31:0] ram_data_i,
   output logic        empty_o
);

   localparam int CNT_W = DEPTH_LOG2 + 1;

   typedef struct packed {
      logic [29:0] addr;
      logic [3:0]  sel;
      logic [31:0] data;
   } entry_t;

   entry_t                entries_q [DEPTH];
   logic [DEPTH_LOG2-1:0] head_q;
   logic [DEPTH_LOG2-1:0] tail_q;
   logic [CNT_W-1:0]      count_q;

   logic   full;
   logic   is_empty;
   logic   hit;
   logic   stall;
   logic   accept;
   logic   push;
   logic   load;
   logic   drain;
   entry_t head_entry;

   assign full       = (count_q == CNT_W'(DEPTH));
   assign is_empty   = (count_q == '0);
   assign head_entry = entries_q[head_q];

   // Only the count entries starting at head are live; stale slots must not stall loads.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(i) < count_q) &&
             (entries_q[head_q + DEPTH_LOG2'(i)].addr == mem_addr_i[31:2])) begin
            hit = 1'b1;
         end
      end
   end

   assign stall  = ~rst & mem_ce_i & (mem_we_i ? full : hit);
   assign accept = mem_ce_i & ~stall;
   assign push   = ~rst & accept & mem_we_i;
   assign load   = ~rst & accept & ~mem_we_i;
   // A stalled request still leaves the RAM port free, so draining continues under a stall.
   assign drain  = ~rst & ~accept & ~is_empty;

   // NOTE: entry storage has no reset; count/pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         entries_q[tail_q] <= '{addr: mem_addr_i[31:2], sel: mem_sel_i, data: mem_data_i};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            tail_q  <= tail_q + DEPTH_LOG2'(1);
            count_q <= count_q + CNT_W'(1);
         end
         if (drain) begin
            head_q  <= head_q + DEPTH_LOG2'(1);
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

   always_comb begin
      mem_data_o = '0;
      ram_ce_o   = 1'b0;
      ram_we_o   = 1'b0;
      ram_addr_o = '0;
      ram_sel_o  = '0;
      ram_data_o = '0;
      if (load) begin
         ram_ce_o   = 1'b1;
         ram_addr_o = mem_addr_i;
         ram_sel_o  = mem_sel_i;
         mem_data_o = ram_data_i;
      end else if (drain) begin
         ram_ce_o   = 1'b1;
         ram_we_o   = 1'b1;
         ram_addr_o = {head_entry.addr, 2'b00};
         ram_sel_o  = head_entry.sel;
         ram_data_o = head_entry.data;
      end
   end

   assign stall_req_o = stall;
   assign empty_o     = rst | is_empty;

   assert property (@(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH));

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the MEM stage and the single-port data RAM (synchronous write, combinational read).
- Stores are queued, and the MEM stage keeps going without waiting on the RAM.
- Loads go straight to the RAM. Queued stores drain in cycles when no CPU access is accepted.
- A load whose word address matches a queued store stalls until that store has drained. There is no partial-byte forwarding.

Parameters:
DEPTH, 4, number of store entries (power of two, >=2)
DEPTH_LOG2, 2, log2(DEPTH); pointer width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
mem_ce_i  input  1  CPU access request this cycle
mem_we_i  input  1  1=store, 0=load
mem_addr_i  input  32  byte address; bits [31:2] used as word address
mem_sel_i  input  4  byte enables, bit3 = data[31:24]
mem_data_i  input  32  store data
mem_data_o  output  32  load result; valid when load accepted, else 0
stall_req_o  output  1  request not accepted; CPU holds all mem_* inputs next cycle
ram_ce_o  output  1  RAM chip enable
ram_we_o  output  1  RAM write enable
ram_addr_o  output  32  RAM address
ram_sel_o  output  4  RAM byte enables
ram_data_o  output  32  RAM write data
ram_data_i  input  32  RAM combinational read data
empty_o  output  1  buffer holds no entries (registered-state derived)

Behaviour:
- State: DEPTH entries of {addr[31:2], sel[3:0], data[31:0]}, head/tail pointers (DEPTH_LOG2 bits, wrap modulo DEPTH), count (DEPTH_LOG2+1 bits).
- Reset (rst=1 at edge): count=0, head=tail=0. Entry contents are don't-care. Any pending stores are discarded, including mid-drain.
- While rst=1, outputs are forced:
  - stall_req_o=0, ram_ce_o=0, ram_we_o=0, ram_addr_o=0, ram_sel_o=0, ram_data_o=0, mem_data_o=0, empty_o=1.
- hit: combinational. 1 when some valid entry's word address equals mem_addr_i[31:2]. Only entries within count from head are compared.
- stall_req_o (combinational):
  - mem_ce_i & mem_we_i & count==DEPTH, or
  - mem_ce_i & ~mem_we_i & hit.
- accept = mem_ce_i & ~stall_req_o.
- Accepted load:
  - ram_ce_o=1, ram_we_o=0, ram_addr_o=mem_addr_i, ram_sel_o=mem_sel_i, ram_data_o=0.
  - mem_data_o=ram_data_i in the same cycle (zero latency). No drain this cycle.
- Accepted store:
  - Written into entry[tail] at the edge; tail+1, count+1.
  - RAM port idle this cycle (ram_ce_o=0). The store reaches the RAM no earlier than the next non-accept cycle.
- Drain (no accept this cycle, i.e. CPU idle or stalled, and count>0):
  - ram_ce_o=1, ram_we_o=1, ram_addr_o={entry[head].addr,2'b00}, ram_sel_o/ram_data_o from entry[head].
  - head+1, count-1 at the edge.
- No accept and count==0: all ram_* outputs 0.
- mem_data_o=0 whenever no load is accepted.
- Push and pop never happen in the same cycle, because a drain requires no accept.
- Ordering: stores reach the RAM in strict FIFO order. Entries are never merged.
- A full buffer plus a store request: stall. The drain that cycle frees one entry, and the held store is accepted next cycle.
- A load hit: stall each cycle, draining one entry per cycle, until no matching entry remains. The load is then accepted.
- Worst-case load stall = DEPTH cycles.
- Pointer wrap: DEPTH-1 -> 0. Count saturates by construction, and never exceeds DEPTH nor underflows.
- empty_o = (count==0).

Test Plan:
- Reset, store 0x11223344 @0x10 sel 1111, then idle:
  - Next cycle: ram_we_o=1, ram_addr_o=0x10, ram_data_o=0x11223344.
  - Then load @0x10 -> mem_data_o=0x11223344, stall_req_o=0.
- Stores to 0x00,0x04,0x08,0x0C,0x20 back-to-back (DEPTH=4):
  - The 0x20 store has stall_req_o=1 for 1 cycle, with drain of 0x00 that cycle.
  - 0x20 is accepted next cycle. RAM write order is 0x00,0x04,0x08,0x0C,0x20.
- Store 0xAA @0x40 sel 0001, then immediately load @0x42:
  - stall_req_o=1 for 1 cycle while 0x40 drains.
  - The load then returns a value with byte0=0xAA.
- Queue 2 stores to 0x100/0x104, then 3 loads to 0x200 (no hit):
  - No stalls, and ram_we_o=0 during the loads.
  - The stores drain in the 2 idle cycles after the loads; empty_o returns to 1.
- Queue 3 stores, assert rst 1 cycle mid-drain:
  - empty_o=1 after the edge. No further RAM writes occur.
  - A load of an undrained address returns the old RAM content.
- Wrap: 10 store/idle pairs with DEPTH=4:
  - Each store is written to the RAM exactly once, in order, with correct data after the pointers wrap.
